boot_sequencer: RTL

- Power-on/boot controller for the chipset.
- Debounces `reset_button` and holds the CPU in reset while it copies a ROM image into RAM, one word per cycle.
- Then releases the CPU and asserts `flag_execute_from_ram`.
- Sole owner of the RAM write port during boot; the CPU owns the RAM write port after boot.

---
 rtl/boot_sequencer_if.sv | 31 +++
 rtl/boot_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/boot_sequencer_if.sv
// Boot sequencer bus: button input, ROM read port, RAM port and CPU boot controls.
// The master modport is the sequencer; the slave modport is the surrounding chipset.
interface boot_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  reset_button;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  cpu_reset;
  logic [ADDR_WIDTH-1:0] boot_pc;
  logic                  is_powered_on;
  logic                  flag_execute_from_ram;
  logic                  boot_error;

  modport master (
    input  reset_button, rom_data, ram_rdata,
    output rom_addr, ram_addr, ram_wdata, ram_we, cpu_reset, boot_pc,
           is_powered_on, flag_execute_from_ram, boot_error
  );

  modport slave (
    output reset_button, rom_data, ram_rdata,
    input  rom_addr, ram_addr, ram_wdata, ram_we, cpu_reset, boot_pc,
           is_powered_on, flag_execute_from_ram, boot_error
  );
endinterface

// File: rtl/boot_sequencer.sv
// Boot sequencer: debounces the reset button, copies a ROM image into RAM one word per
// cycle while holding the CPU in reset, then releases the CPU to execute from RAM.
// Define BOOT_SEQUENCER_VERIFY_EN to add a read-back VERIFY pass and a HALT error state.
module boot_sequencer #(
  parameter int unsigned           ADDR_WIDTH      = 16,
  parameter int unsigned           DATA_WIDTH      = 16,
  parameter int unsigned           COPY_WORDS      = 256,
  parameter logic [ADDR_WIDTH-1:0] ROM_BASE        = '0,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE        = '0,
  parameter int unsigned           DEBOUNCE_CYCLES = 4
) (
  input logic              clk,
  input logic              reset,
  boot_sequencer_if.master bus
);

  // Word index needs one extra bit so COPY_WORDS == 2^ADDR_WIDTH is representable.
  localparam int unsigned          IdxW    = ADDR_WIDTH + 1;
  localparam logic [IdxW-1:0]      LastIdx = IdxW'(COPY_WORDS);
  localparam int unsigned          DbW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0]       DbMax   = DbW'(DEBOUNCE_CYCLES);

`ifdef BOOT_SEQUENCER_VERIFY_EN
  typedef enum logic [2:0] {StOff, StCopy, StVerify, StHalt, StRun} state_e;
`else
  typedef enum logic [1:0] {StOff, StCopy, StRun} state_e;
`endif

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DbW-1:0]        db_cnt_q, db_cnt_d;
  logic                  pressed;
  logic                  rd_more;
  logic                  we;
  logic                  run_active;
  logic [ADDR_WIDTH-1:0] idx_off;
  logic [DATA_WIDTH-1:0] wdata;

  // A saturated counter is a valid press; it clears together with the release.
  assign pressed = (db_cnt_q == DbMax);
  assign rd_more = (idx_q < LastIdx);
  assign idx_off = idx_q[ADDR_WIDTH-1:0];

  // State, word index, held RAM address and debounce counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StOff;
      idx_q      <= '0;
      ram_addr_q <= RAM_BASE;
      db_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ram_addr_q <= ram_addr_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // Button debounce: count consecutive high samples, saturate, clear on low.
  always_comb begin
    db_cnt_d = db_cnt_q;
    if (state_q != StOff) begin
      if (!bus.reset_button) begin
        db_cnt_d = '0;
      end else if (db_cnt_q != DbMax) begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  // Next-state logic: copy sequencing, optional verify, and press freeze/release restart.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ram_addr_d = ram_addr_q;
    we         = 1'b0;
    if (pressed) begin
      // Everything stays frozen while held; the release restarts the copy from word 0.
      if (!bus.reset_button) begin
        state_d = StCopy;
        idx_d   = '0;
      end
    end else begin
      unique case (state_q)
        StOff: begin
          state_d = StCopy;
          idx_d   = '0;
        end
        StCopy: begin
          // ROM data for word idx-1 arrives this cycle.
          we = (idx_q != '0);
          if (rd_more) begin
            idx_d      = idx_q + IdxW'(1);
            ram_addr_d = RAM_BASE + idx_off;
          end else begin
`ifdef BOOT_SEQUENCER_VERIFY_EN
            state_d = StVerify;
            idx_d   = '0;
`else
            state_d = StRun;
`endif
          end
        end
`ifdef BOOT_SEQUENCER_VERIFY_EN
        StVerify: begin
          ram_addr_d = RAM_BASE + idx_off;
          if ((idx_q != '0) && (bus.rom_data != bus.ram_rdata)) begin
            state_d = StHalt;
          end else if (rd_more) begin
            idx_d = idx_q + IdxW'(1);
          end else begin
            state_d = StRun;
          end
        end
        StHalt: begin
          state_d = StHalt;
        end
`endif
        StRun: begin
          state_d = StRun;
        end
        default: begin
          state_d = StOff;
        end
      endcase
    end
  end

  // Output decode from registered state.
  always_comb begin
    run_active = (state_q == StRun) && !pressed;
    wdata      = we ? bus.rom_data : '0;
  end

  assign bus.rom_addr              = ROM_BASE + idx_off;
`ifdef BOOT_SEQUENCER_VERIFY_EN
  // Verify reads RAM at the same offset as ROM, so the address is not delayed there.
  assign bus.ram_addr              = (state_q == StVerify) ? (RAM_BASE + idx_off) : ram_addr_q;
  assign bus.boot_error            = (state_q == StHalt);
`else
  logic unused_rdata;
  assign unused_rdata              = ^bus.ram_rdata;
  assign bus.ram_addr              = ram_addr_q;
  assign bus.boot_error            = 1'b0;
`endif
  assign bus.ram_wdata             = wdata;
  assign bus.ram_we                = we;
  assign bus.cpu_reset             = !run_active;
  assign bus.flag_execute_from_ram = run_active;
  assign bus.is_powered_on         = (state_q != StOff);
  assign bus.boot_pc               = RAM_BASE;

endmodule
